// File: rtl/branch_rs_if.sv
// Branch reservation-station scheduler interface.
// Optional statistics counters are present only when BRANCH_RS_STATS_EN is defined.
//
// Handshake semantics: dispatchValid is decode's "valid" for an RS write, and
// writeReq is the matching "ready". An allocation takes place on a rising clk
// edge where writeReq is non-zero. dispatchStall flags a cycle where dispatch
// is valid but cannot be accepted. On the issue side, selectReq is each entry's
// "valid" and execute is the branch unit's "ready". A grant (selected) is
// combinational, and it is consumed at the edge that ends the grant cycle.
interface branch_rs_if #(
    parameter int ENTRIES = 4,
    parameter int IDX     = $clog2(ENTRIES)
);
    logic               dispatchValid;
    logic [ENTRIES-1:0] busy;
    logic [ENTRIES-1:0] selectReq;
    logic               execute;
    logic               clear;
    logic               validCommit;
    logic [ENTRIES-1:0] writeReq;
    logic [ENTRIES-1:0] selected;
    logic               issueValid;
    logic [IDX-1:0]     issueIndex;
    logic               rsFull;
    logic               dispatchStall;
`ifdef BRANCH_RS_STATS_EN
    logic [15:0]        issueCount;
    logic [15:0]        stallCount;
`endif

    // Decode / entry / branch-unit side
    modport master (
        output dispatchValid, busy, selectReq, execute, clear, validCommit,
        input  writeReq, selected, issueValid, issueIndex, rsFull, dispatchStall
`ifdef BRANCH_RS_STATS_EN
        , input issueCount, stallCount
`endif
    );

    // Scheduler side
    modport slave (
        input  dispatchValid, busy, selectReq, execute, clear, validCommit,
        output writeReq, selected, issueValid, issueIndex, rsFull, dispatchStall
`ifdef BRANCH_RS_STATS_EN
        , output issueCount, stallCount
`endif
    );
endinterface

// File: rtl/branch_rs_scheduler.sv
// Branch reservation-station scheduler: allocates free entries lowest-index
// first and issues the oldest ready entry using a registered age matrix.
// Optional feature macro: BRANCH_RS_STATS_EN (issue/stall saturating counters).
module branch_rs_scheduler #(
    parameter int ENTRIES = 4,
    parameter int IDX     = $clog2(ENTRIES)
) (
    input logic        clk,
    input logic        globalReset,
    branch_rs_if.slave rs
);

    // older_q[i][j] = 1 means entry i was allocated before entry j.
    // The diagonal is never set, so it reads as "not older than itself".
    logic [ENTRIES-1:0] older_q [ENTRIES];

    logic               flush;
    logic               rs_full;
    logic [ENTRIES-1:0] cand;
    logic [ENTRIES-1:0] write_req;
    logic [ENTRIES-1:0] blocked;
    logic [ENTRIES-1:0] sel;
    logic [IDX-1:0]     issue_idx;

    assign flush   = rs.clear & rs.validCommit;
    assign rs_full = &rs.busy;
    assign cand    = rs.selectReq & rs.busy;

    // Allocation: lowest-index free entry, suppressed on full, flush or reset
    always_comb begin
        logic found;
        write_req = '0;
        found     = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!rs.busy[i] && !found) begin
                write_req[i] = 1'b1;
                found        = 1'b1;
            end
        end
        if (!rs.dispatchValid || rs_full || flush || globalReset)
            write_req = '0;
    end

    // Issue: a candidate loses to any older candidate, or to a lower-index
    // candidate when neither is older (only possible after reset/flush)
    always_comb begin
        blocked = '0;
        sel     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (cand[j] && (older_q[j][i] || (!older_q[i][j] && (j < i))))
                    blocked[i] = 1'b1;
            end
            sel[i] = cand[i] & ~blocked[i];
        end
        if (!rs.execute || flush || globalReset)
            sel = '0;
    end

    // Binary index of the one-hot grant; zero when nothing is granted
    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel[i])
                issue_idx = issue_idx | IDX'(i);
        end
    end

    assign rs.writeReq      = write_req;
    assign rs.selected      = sel;
    assign rs.issueValid    = |sel;
    assign rs.issueIndex    = issue_idx;
    assign rs.rsFull        = rs_full;
    assign rs.dispatchStall = rs.dispatchValid & (rs_full | flush) & ~globalReset;

    // Age matrix: cleared by reset or flush; a new entry becomes younger than all others
    always_ff @(posedge clk) begin
        if (globalReset || flush) begin
            for (int i = 0; i < ENTRIES; i++)
                older_q[i] <= '0;
        end else begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (write_req[k]) begin
                    for (int j = 0; j < ENTRIES; j++) begin
                        if (j != k) begin
                            older_q[k][j] <= 1'b0;
                            older_q[j][k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef BRANCH_RS_STATS_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] stall_cnt_q;

    // Saturating event counters; flush does not clear them
    always_ff @(posedge clk) begin
        if (globalReset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (rs.issueValid && (issue_cnt_q != 16'hFFFF))
                issue_cnt_q <= issue_cnt_q + 16'd1;
            if (rs.dispatchStall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign rs.issueCount = issue_cnt_q;
    assign rs.stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Directed testbench for branch_rs_scheduler (ENTRIES=4).
// Counter checks are compiled in when BRANCH_RS_STATS_EN is defined.
module tb_branch_rs_scheduler;

  logic clk;
  logic globalReset;
  int   checks;
  int   errors;

  branch_rs_if #(.ENTRIES(4)) rs_if ();

  branch_rs_scheduler #(.ENTRIES(4)) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .rs          (rs_if)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    globalReset          = 1'b1;
    rs_if.dispatchValid  = 1'b1;
    rs_if.busy           = 4'b0000;
    rs_if.selectReq      = 4'b1111;
    rs_if.execute        = 1'b1;
    rs_if.clear          = 1'b0;
    rs_if.validCommit    = 1'b0;

    // outputs held low during reset
    tick();
    tick();
    check("rst_writeReq", 32'(rs_if.writeReq), 32'h0);
    check("rst_selected", 32'(rs_if.selected), 32'h0);
    check("rst_issueValid", 32'(rs_if.issueValid), 32'h0);
    check("rst_issueIndex", 32'(rs_if.issueIndex), 32'h0);
    check("rst_stall", 32'(rs_if.dispatchStall), 32'h0);
    check("rst_rsFull0", 32'(rs_if.rsFull), 32'h0);
`ifdef BRANCH_RS_STATS_EN
    check("rst_issueCount", 32'(rs_if.issueCount), 32'h0);
    check("rst_stallCount", 32'(rs_if.stallCount), 32'h0);
`endif
    rs_if.busy = 4'b1111;
    #1;
    check("rst_rsFull1", 32'(rs_if.rsFull), 32'h1);
    tick();

    // first allocation after reset
    globalReset         = 1'b0;
    rs_if.busy          = 4'b0000;
    rs_if.selectReq     = 4'b0000;
    rs_if.execute       = 1'b0;
    rs_if.dispatchValid = 1'b1;
    #1;
    check("alloc_first", 32'(rs_if.writeReq), 32'h1);
    check("alloc_rsFull", 32'(rs_if.rsFull), 32'h0);
    check("alloc_stall", 32'(rs_if.dispatchStall), 32'h0);

    // allocate entries 2, 0, 1 in that order
    rs_if.busy = 4'b0011;
    #1;
    check("alloc_e2", 32'(rs_if.writeReq), 32'h4);
    tick();
    rs_if.busy = 4'b0110;
    #1;
    check("alloc_e0", 32'(rs_if.writeReq), 32'h1);
    tick();
    rs_if.busy = 4'b0101;
    #1;
    check("alloc_e1", 32'(rs_if.writeReq), 32'h2);
    tick();

    // oldest-first grants: order is 2, 0, 1
    rs_if.dispatchValid = 1'b0;
    rs_if.busy          = 4'b0111;
    rs_if.selectReq     = 4'b0111;
    rs_if.execute       = 1'b1;
    #1;
    check("grant_oldest", 32'(rs_if.selected), 32'h4);
    check("grant_oldest_idx", 32'(rs_if.issueIndex), 32'h2);
    check("grant_oldest_vld", 32'(rs_if.issueValid), 32'h1);
    rs_if.selectReq = 4'b0011;
    #1;
    check("grant_0_over_1", 32'(rs_if.selected), 32'h1);
    check("grant_0_idx", 32'(rs_if.issueIndex), 32'h0);
    rs_if.selectReq = 4'b0010;
    #1;
    check("grant_single1", 32'(rs_if.selected), 32'h2);
    check("grant_single1_idx", 32'(rs_if.issueIndex), 32'h1);

    // allocation and grant in the same cycle
    rs_if.dispatchValid = 1'b1;
    rs_if.selectReq     = 4'b0100;
    #1;
    check("both_writeReq", 32'(rs_if.writeReq), 32'h8);
    check("both_selected", 32'(rs_if.selected), 32'h4);
    tick();

    // full RS blocks dispatch
    rs_if.busy      = 4'b1111;
    rs_if.selectReq = 4'b0000;
    rs_if.execute   = 1'b0;
    #1;
    check("full_writeReq", 32'(rs_if.writeReq), 32'h0);
    check("full_rsFull", 32'(rs_if.rsFull), 32'h1);
    check("full_stall", 32'(rs_if.dispatchStall), 32'h1);

    // entry 0 older than the newly allocated entry 3
    rs_if.selectReq = 4'b1001;
    rs_if.execute   = 1'b1;
    #1;
    check("grant_0_over_3", 32'(rs_if.selected), 32'h1);

    // no grant without execute
    rs_if.selectReq = 4'b1111;
    rs_if.execute   = 1'b0;
    #1;
    check("noexec_selected", 32'(rs_if.selected), 32'h0);
    check("noexec_issueValid", 32'(rs_if.issueValid), 32'h0);

    // request from a non-busy entry is ignored
    rs_if.execute       = 1'b1;
    rs_if.busy          = 4'b0111;
    rs_if.selectReq     = 4'b1000;
    rs_if.dispatchValid = 1'b0;
    #1;
    check("notbusy_selected", 32'(rs_if.selected), 32'h0);

    // clear without validCommit is not a flush
    rs_if.busy          = 4'b0101;
    rs_if.selectReq     = 4'b0101;
    rs_if.clear         = 1'b1;
    rs_if.validCommit   = 1'b0;
    rs_if.dispatchValid = 1'b1;
    #1;
    check("noflush_selected", 32'(rs_if.selected), 32'h4);
    check("noflush_writeReq", 32'(rs_if.writeReq), 32'h2);

    // flush: nothing allocated or granted, stall raised
    rs_if.validCommit = 1'b1;
    rs_if.selectReq   = 4'b0011;
    rs_if.busy        = 4'b0011;
    #1;
    check("flush_selected", 32'(rs_if.selected), 32'h0);
    check("flush_writeReq", 32'(rs_if.writeReq), 32'h0);
    check("flush_stall", 32'(rs_if.dispatchStall), 32'h1);
    tick();

    // after flush, ages are equal: lowest index wins (2 was older before)
    rs_if.clear         = 1'b0;
    rs_if.validCommit   = 1'b0;
    rs_if.dispatchValid = 1'b0;
    rs_if.busy          = 4'b0101;
    rs_if.selectReq     = 4'b0101;
    #1;
    check("tie_after_flush", 32'(rs_if.selected), 32'h1);
    check("tie_after_flush_idx", 32'(rs_if.issueIndex), 32'h0);
    tick();

    // rebuild an order where 2 is older than 0
    rs_if.execute       = 1'b0;
    rs_if.selectReq     = 4'b0000;
    rs_if.dispatchValid = 1'b1;
    rs_if.busy          = 4'b1011;
    #1;
    check("realloc_e2", 32'(rs_if.writeReq), 32'h4);
    tick();
    rs_if.busy = 4'b1110;
    #1;
    check("realloc_e0", 32'(rs_if.writeReq), 32'h1);
    tick();
    rs_if.dispatchValid = 1'b0;
    rs_if.busy          = 4'b0101;
    rs_if.selectReq     = 4'b0101;
    rs_if.execute       = 1'b1;
    #1;
    check("age_before_reset", 32'(rs_if.selected), 32'h4);

    // reset mid-operation: no grant, no allocation, ordering discarded
    globalReset         = 1'b1;
    rs_if.dispatchValid = 1'b1;
    rs_if.busy          = 4'b1110;
    #1;
    check("midrst_selected", 32'(rs_if.selected), 32'h0);
    check("midrst_writeReq", 32'(rs_if.writeReq), 32'h0);
    check("midrst_stall", 32'(rs_if.dispatchStall), 32'h0);
    tick();
    globalReset         = 1'b0;
    rs_if.dispatchValid = 1'b0;
    rs_if.busy          = 4'b0101;
    rs_if.selectReq     = 4'b0101;
    #1;
    check("tie_after_reset", 32'(rs_if.selected), 32'h1);

`ifdef BRANCH_RS_STATS_EN
    // saturating counters
    globalReset = 1'b1;
    tick();
    globalReset         = 1'b0;
    rs_if.busy          = 4'b1111;
    rs_if.selectReq     = 4'b0001;
    rs_if.execute       = 1'b1;
    rs_if.dispatchValid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("issueCount_3", 32'(rs_if.issueCount), 32'd3);
    check("stallCount_3", 32'(rs_if.stallCount), 32'd3);
    repeat (70000) @(posedge clk);
    #1;
    check("issueCount_sat", 32'(rs_if.issueCount), 32'hFFFF);
    check("stallCount_sat", 32'(rs_if.stallCount), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
